// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and helpers for the register-file writeback arbiter slice.
// Defaults match reg_file so both sides agree on data and address widths.
package rf_wb_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned CNT_WIDTH      = 32;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // A single requester still needs a 1-bit pointer so the ports stay legal.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after rr_ptr and
// moves the pointer just past the winner when the grant is consumed.
module rr_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = ptr_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_valid,
  input  logic          advance,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(rr_ptr) + k) % N);
      if (!found && req_valid[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= IW'((32'(grant_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters, stages
// the winning write for one cycle and bypasses it onto both read ports.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  input  logic [ADDR_WIDTH-1:0]      raddr1,
  input  logic [ADDR_WIDTH-1:0]      raddr2,
  input  logic [DATA_WIDTH-1:0]      rf_rdata1,
  input  logic [DATA_WIDTH-1:0]      rf_rdata2,
  output logic [DATA_WIDTH-1:0]      fwd_rdata1,
  output logic [DATA_WIDTH-1:0]      fwd_rdata2,
  output logic [CNT_WIDTH-1:0]       conflict_cnt
);

  localparam int unsigned IW = ptr_width(NREQ);

  logic [NREQ-1:0]       grant_onehot;
  logic [IW-1:0]         grant_idx;
  logic                  accept;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  int unsigned           n_valid;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .advance      (accept),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign req_ready = rst_n ? grant_onehot : '0;
  assign accept    = |req_ready;
  assign sel_addr  = req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data  = req_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Gating with rst_n drops a staged write in the very cycle reset is applied.
  assign rf_wen = wen_q & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (accept) begin
      wen_q    <= (sel_addr != '0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      wen_q    <= 1'b0;
    end
  end

  always_comb begin
    n_valid = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      n_valid = n_valid + 32'(req_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (n_valid >= 2) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  always_comb begin
    fwd_rdata1 = rf_rdata1;
    if (raddr1 == '0) begin
      fwd_rdata1 = '0;
    end else if (rf_wen && (raddr1 == rf_waddr)) begin
      fwd_rdata1 = rf_wdata;
    end
  end

  always_comb begin
    fwd_rdata2 = rf_rdata2;
    if (raddr2 == '0) begin
      fwd_rdata2 = '0;
    end else if (rf_wen && (raddr2 == rf_waddr)) begin
      fwd_rdata2 = rf_wdata;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter with a behavioural register file and
// a transaction-level reference model of arbitration, staging and bypass.
module tb_rf_wb_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr, raddr1, raddr2;
  logic [DW-1:0]   rf_wdata, rf_rdata1, rf_rdata2, fwd_rdata1, fwd_rdata2;
  logic [31:0]     conflict_cnt;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .raddr1(raddr1), .raddr2(raddr2), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Environment register file, preloaded with a recognisable pattern (x0 too).
  logic [DW-1:0] rf_mem [32];
  logic mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA500_0000 | i;
      mem_init <= 1'b1;
    end else if (rf_wen) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata1 = rf_mem[raddr1];
  assign rf_rdata2 = rf_mem[raddr2];

  // Reference model state
  int          m_ptr;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_cnt;
  logic [31:0] m_rf [32];
  int          waits [NREQ];
  int          max_wait;

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = rst_n ? exp_grant(req_valid) : -1;
    return (g < 0) ? '0 : NREQ'(1) << g;
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] ra);
    if (ra == 0) return 32'h0;
    if (m_wen && rst_n && ra == m_waddr) return m_wdata;
    return m_rf[ra];
  endfunction

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advance one clock and apply the specified rules to the model.
  task automatic cycle();
    int g;
    bit rst_now, conf;
    logic [4:0] a;
    logic [31:0] d;
    rst_now = !rst_n;
    g = rst_now ? -1 : exp_grant(req_valid);
    conf = $countones(req_valid) >= 2;
    a = (g < 0) ? 5'd0 : req_addr[g*AW +: AW];
    d = (g < 0) ? 32'd0 : req_data[g*DW +: DW];
    @(posedge clk);
    if (rst_now) begin
      m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
      for (int i = 0; i < NREQ; i++) waits[i] = 0;
    end else begin
      if (m_wen) m_rf[m_waddr] = m_wdata;
      for (int i = 0; i < NREQ; i++) begin
        if (g == i) waits[i] = 0;
        else if (g >= 0 && req_valid[i]) begin
          waits[i]++;
          if (waits[i] > max_wait) max_wait = waits[i];
        end
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % NREQ; m_waddr = a; m_wdata = d; m_wen = (a != 0);
      end else begin
        m_wen = 0;
      end
      if (conf && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    cycle();
    cycle();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", rf_wen); end
    checks++; if (conflict_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", conflict_cnt); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_stage: got %h/%h expected 0/0", rf_waddr, rf_wdata); end
    rst_n = 1'b1; req_valid = 2'b00;
  endtask

  task automatic test_single_write();
    req_valid = 2'b01; set_req(0, 5'd5, 32'hDEAD_BEEF);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    cycle();
    req_valid = 2'b00; raddr1 = 5'd5;
    #1;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5) begin errors++; $display("FAIL single_stage: got wen=%b addr=%0d expected 1/5", rf_wen, rf_waddr); end
    checks++; if (fwd_rdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_bypass: got %h expected deadbeef", fwd_rdata1); end
    cycle();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL single_wen_drop: got %b expected 0", rf_wen); end
    checks++; if (fwd_rdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rf_read: got %h expected deadbeef", fwd_rdata1); end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    rst_n = 1'b0; req_valid = 2'b00;
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_valid = 2'b11;
      set_req(0, 5'($urandom_range(1, 31)), $urandom);
      set_req(1, 5'($urandom_range(1, 31)), $urandom);
      #1;
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== want || req_ready !== exp_ready()) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", c, req_ready, want); end
      cycle();
      checks++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin errors++; $display("FAIL contention_stage%0d: got %h/%h expected %h/%h", c, rf_waddr, rf_wdata, m_waddr, m_wdata); end
    end
    req_valid = 2'b00;
    #1;
    checks++; if (conflict_cnt !== 32'd4) begin errors++; $display("FAIL contention_cnt: got %0d expected 4", conflict_cnt); end
  endtask

  task automatic test_x0();
    req_valid = 2'b10; set_req(1, 5'd0, 32'd1);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready: got %b expected 10", req_ready); end
    cycle();
    req_valid = 2'b00; raddr2 = 5'd0;
    #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wen: got %b expected 0", rf_wen); end
    checks++; if (fwd_rdata2 !== 32'd0) begin errors++; $display("FAIL x0_fwd: got %h expected 0", fwd_rdata2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] saved;
    saved = m_rf[7];
    req_valid = 2'b01; set_req(0, 5'd7, 32'h1234_5678);
    cycle();
    req_valid = 2'b00; raddr1 = 5'd7;
    #1;
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL midrst_staged: got %b expected 1", rf_wen); end
    rst_n = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b0 || fwd_rdata1 !== saved) begin errors++; $display("FAIL midrst_drop: got wen=%b fwd=%h expected 0/%h", rf_wen, fwd_rdata1, saved); end
    cycle();
    checks++; if (rf_mem[7] !== saved) begin errors++; $display("FAIL midrst_r7: got %h expected %h", rf_mem[7], saved); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int g;
    max_wait = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
          req_valid[i] = 1'b1;
          set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
        end
      end
      raddr1 = 5'($urandom); raddr2 = ($urandom_range(0, 1) == 0) ? m_waddr : 5'($urandom);
      #1;
      checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", c, req_ready, exp_ready()); end
      checks++; if (rf_wen !== (m_wen & rst_n) || (m_wen && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))) begin errors++; $display("FAIL rand_stage@%0d: got %b/%h/%h expected %b/%h/%h", c, rf_wen, rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata); end
      checks++; if (fwd_rdata1 !== exp_fwd(raddr1) || fwd_rdata2 !== exp_fwd(raddr2)) begin errors++; $display("FAIL rand_fwd@%0d: got %h/%h expected %h/%h", c, fwd_rdata1, fwd_rdata2, exp_fwd(raddr1), exp_fwd(raddr2)); end
      g = exp_grant(req_valid);
      cycle();
      if (g >= 0) req_valid[g] = 1'b0;
      checks++; if (conflict_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt@%0d: got %0d expected %0d", c, conflict_cnt, m_cnt); end
    end
    req_valid = '0;
    checks++; if (max_wait > NREQ - 1) begin errors++; $display("FAIL starvation: got wait %0d expected <= %0d", max_wait, NREQ - 1); end
  endtask

  task automatic test_saturation();
    req_valid = 2'b11;
    force dut.conflict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt;
    m_cnt = 32'hFFFF_FFFE;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++; if (conflict_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_cnt%0d: got %h expected ffffffff", c, conflict_cnt); end
    end
    req_valid = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    raddr1 = '0; raddr2 = '0;
    m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; max_wait = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'hA500_0000 | i;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    test_reset();
    test_single_write();
    test_contention();
    test_x0();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
